// File: rtl/vram_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_dma_arbiter
// Purpose  : Hands the external async SRAM between the Z80 (default owner)
//            and the VGA row-buffer DMA using the Z80 BUSRQ/BUSAK handshake,
//            with guard cycles around the grant and an acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module vram_dma_arbiter #(
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  // VGA DMA side
  input  logic        DMA_REQ,
  output logic        DMA_ACK,
  input  logic [16:0] DMA_ADR,
  output logic [7:0]  DMA_DATA,
  // Z80 side
  output logic        CPU_BUSRQ_N,
  input  logic        CPU_BUSAK_N,
  input  logic [15:0] CPU_ADR,
  input  logic [7:0]  CPU_DOUT,
  output logic [7:0]  CPU_DIN,
  input  logic        CPU_MREQ_N,
  input  logic        CPU_RD_N,
  input  logic        CPU_WR_N,
  // SRAM side
  output logic [16:0] SRAM_ADR,
  input  logic [7:0]  SRAM_DIN,
  output logic [7:0]  SRAM_DOUT,
  output logic        SRAM_DOE,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        TIMEOUT_ERR
);

  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_GUARD_IN  = 3'd2,
    S_GRANT     = 3'd3,
    S_GUARD_OUT = 3'd4,
    S_RELEASE   = 3'd5
  } state_t;

  state_t        state_q;
  logic          owner_dma_q;   // 1 = SRAM belongs to the DMA
  logic          busrq_n_q;
  logic          ack_q;
  logic          err_q;
  logic [7:0]    tmo_q;
  logic [GW-1:0] guard_q;
  logic          guard_done;

  // Last guard cycle: the counter started at zero on guard-state entry
  assign guard_done = (32'(guard_q) + 32'd1) >= GUARD_CYCLES;

  // Handshake sequencer; every output it produces is registered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      owner_dma_q <= 1'b0;
      busrq_n_q   <= 1'b1;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      guard_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busrq_n_q <= 1'b1;
          if (DMA_REQ) begin
            state_q   <= S_REQ;
            busrq_n_q <= 1'b0;
            tmo_q     <= '0;
          end
        end
        S_REQ: begin
          tmo_q <= tmo_q + 8'd1;
          if (!CPU_BUSAK_N) begin
            // CPU has let go of the bus: SRAM switches to the DMA here
            owner_dma_q <= 1'b1;
            guard_q     <= '0;
            state_q     <= (GUARD_CYCLES == 0) ? S_GRANT : S_GUARD_IN;
          end else if (!DMA_REQ) begin
            state_q   <= S_RELEASE;
            busrq_n_q <= 1'b1;
          end else if (tmo_q + 8'd1 == 8'(ACK_TIMEOUT)) begin
            err_q     <= 1'b1;
            state_q   <= S_RELEASE;
            busrq_n_q <= 1'b1;
          end
        end
        S_GUARD_IN: begin
          if (guard_done) state_q <= S_GRANT;
          else            guard_q <= guard_q + GW'(1);
        end
        S_GRANT: begin
          guard_q <= '0;
          if (CPU_BUSAK_N || !DMA_REQ) begin
            // A lost BUSAK is an error; a dropped request is a normal end
            ack_q <= 1'b0;
            if (CPU_BUSAK_N) err_q <= 1'b1;
            if (GUARD_CYCLES == 0) begin
              state_q     <= S_RELEASE;
              owner_dma_q <= 1'b0;
              busrq_n_q   <= 1'b1;
            end else begin
              state_q <= S_GUARD_OUT;
            end
          end else begin
            ack_q <= 1'b1;
          end
        end
        S_GUARD_OUT: begin
          if (guard_done) begin
            state_q     <= S_RELEASE;
            owner_dma_q <= 1'b0;
            busrq_n_q   <= 1'b1;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        S_RELEASE: begin
          if (CPU_BUSAK_N) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // SRAM steering follows the registered owner; the DMA never writes
  always_comb begin
    if (owner_dma_q) begin
      SRAM_ADR  = DMA_ADR;
      SRAM_DOUT = 8'h00;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b0;
      SRAM_DOE  = 1'b0;
    end else begin
      SRAM_ADR  = {1'b0, CPU_ADR};
      SRAM_DOUT = CPU_DOUT;
      SRAM_WE_N = CPU_MREQ_N | CPU_WR_N;
      SRAM_OE_N = CPU_MREQ_N | CPU_RD_N;
      SRAM_DOE  = ~CPU_MREQ_N & ~CPU_WR_N;
    end
  end

  assign DMA_DATA    = SRAM_DIN;
  assign CPU_DIN     = SRAM_DIN;
  assign DMA_ACK     = ack_q;
  assign CPU_BUSRQ_N = busrq_n_q;
  assign TIMEOUT_ERR = err_q;

endmodule
`default_nettype wire
